// File: rtl/lcd_spi_serializer_if.sv
// ============================================================================
// Module      : lcd_spi_serializer_if
// Description : Upstream byte handshake between a display controller and
//               the PCD8544 SPI serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_spi_serializer_if #(
  parameter int DIV_W = 16
);
  logic [7:0]       data_in;
  logic             command;
  logic             start;
  logic [DIV_W-1:0] div_factor;
  logic             avail;
  logic             busy;

  modport master (
    output data_in, command, start, div_factor,
    input  avail, busy
  );

  modport slave (
    input  data_in, command, start, div_factor,
    output avail, busy
  );
endinterface

`default_nettype wire

// File: rtl/lcd_spi_serializer.sv
// ============================================================================
// Module      : lcd_spi_serializer
// Description : PCD8544 (Nokia 5110) byte serializer: LCD power-on reset
//               pulse, then MSB-first SPI with sce/dc/sclk sequencing.
//               Define SERIALIZER_SCE_BURST_EN to keep sce low across
//               back-to-back bytes (no inter-byte gap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_spi_serializer #(
  parameter int RST_CYCLES = 16,
  parameter int DIV_W      = 16
) (
  input  wire logic            clock,
  input  wire logic            Reset,
  lcd_spi_serializer_if.slave  bus,
  output logic                 mosi,
  output logic                 sclk,
  output logic                 sce,
  output logic                 dc,
  output logic                 rst
);

  localparam int c_RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RST_CYCLES - 1);

  localparam logic [1:0] c_ST_LCD_RST = 2'd0;
  localparam logic [1:0] c_ST_IDLE    = 2'd1;
  localparam logic [1:0] c_ST_SHIFT   = 2'd2;
  localparam logic [1:0] c_ST_GAP     = 2'd3;

  logic [1:0]         r_state;
  logic [c_RST_W-1:0] r_rst_cnt;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [2:0]         r_bit_cnt;
  logic [6:0]         r_shift;
  logic               r_mosi;
  logic               r_sclk;
  logic               r_sce;
  logic               r_dc;
  logic               r_rst;
  logic               r_avail;

  logic [DIV_W-1:0]   w_div_eff;
  logic               w_div_wrap;
  logic               w_byte_end;
  logic               w_load;

  assign w_div_eff  = (bus.div_factor == '0) ? DIV_W'(1) : bus.div_factor;
  assign w_div_wrap = (r_div_cnt == r_div - DIV_W'(1));
  // The byte completes on the 8th falling sclk toggle.
  assign w_byte_end = (r_state == c_ST_SHIFT) && w_div_wrap && r_sclk && (r_bit_cnt == 3'd7);

`ifdef SERIALIZER_SCE_BURST_EN
  assign w_load = bus.start && ((r_state == c_ST_IDLE) || w_byte_end);
`else
  assign w_load = bus.start && (r_state == c_ST_IDLE);
`endif

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= c_ST_LCD_RST;
      r_rst_cnt <= '0;
      r_div     <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_mosi    <= 1'b0;
      r_sclk    <= 1'b0;
      r_sce     <= 1'b1;
      r_dc      <= 1'b0;
      r_rst     <= 1'b0;
      r_avail   <= 1'b0;
    end else begin
      r_avail <= 1'b0;
      case (r_state)
        c_ST_LCD_RST: begin
          if (r_rst_cnt == c_RST_LAST) begin
            r_rst   <= 1'b1;
            r_state <= c_ST_IDLE;
          end else begin
            r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
          end
        end
        c_ST_IDLE: begin
          r_sce  <= 1'b1;
          r_sclk <= 1'b0;
        end
        c_ST_SHIFT: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
            if (r_sclk) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_sce <= 1'b1;
`ifdef SERIALIZER_SCE_BURST_EN
                r_state <= c_ST_IDLE;
`else
                r_state <= c_ST_GAP;
`endif
              end else begin
                r_mosi  <= r_shift[6];
                r_shift <= {r_shift[5:0], 1'b0};
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        c_ST_GAP: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_state   <= c_ST_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        default: r_state <= c_ST_LCD_RST;
      endcase

      // A load overrides the end-of-byte / idle assignments above.
      if (w_load) begin
        r_shift   <= bus.data_in[6:0];
        r_mosi    <= bus.data_in[7];
        r_dc      <= bus.command;
        r_div     <= w_div_eff;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_sclk    <= 1'b0;
        r_sce     <= 1'b0;
        r_avail   <= 1'b1;
        r_state   <= c_ST_SHIFT;
      end
    end
  end

  assign mosi      = r_mosi;
  assign sclk      = r_sclk;
  assign sce       = r_sce;
  assign dc        = r_dc;
  assign rst       = r_rst;
  assign bus.avail = r_avail;
  assign bus.busy  = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lcd_spi_serializer.sv
// ============================================================================
// Module      : tb_lcd_spi_serializer
// Description : Self-checking bench for lcd_spi_serializer (table, random
//               and hand-written corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_spi_serializer;

  localparam int c_RST_CYCLES = 16;
  localparam int c_DIV_W      = 16;
`ifdef SERIALIZER_SCE_BURST_EN
  localparam bit c_BURST = 1'b1;
`else
  localparam bit c_BURST = 1'b0;
`endif

  logic clock = 1'b0;
  logic Reset;
  logic mosi, sclk, sce, dc, rst;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_spi_serializer_if #(.DIV_W(c_DIV_W)) bus ();

  lcd_spi_serializer #(.RST_CYCLES(c_RST_CYCLES), .DIV_W(c_DIV_W)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus),
    .mosi  (mosi),
    .sclk  (sclk),
    .sce   (sce),
    .dc    (dc),
    .rst   (rst)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       cmd;
    int         div;
    logic [7:0] exp_byte;
    logic       exp_dc;
    int         exp_len;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 500) begin
      @(negedge clock);
      t++;
    end
    chk("idle_reached", bus.busy, 0);
  endtask

  // Drives one single-byte transfer and checks the observed wire activity.
  task automatic check_byte(input string tag, input logic [7:0] d, input logic c,
                            input int div, input logic [7:0] exp_byte,
                            input logic exp_dc, input int exp_len);
    logic [7:0] got = '0;
    logic prev = 1'b0;
    int cyc = 0, rises = 0, avails = 0, last_rise = -1, bad_period = 0;
    wait_idle();
    @(negedge clock);
    bus.data_in = d; bus.command = c; bus.div_factor = c_DIV_W'(div); bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    while (!sce && cyc < 2000) begin
      if (bus.avail) avails++;
      if (sclk && !prev) begin
        got = {got[6:0], mosi};
        if (last_rise >= 0 && cyc - last_rise != exp_len / 8) bad_period++;
        last_rise = cyc;
        rises++;
      end
      if (cyc == 2) begin
        bus.data_in = ~d; bus.command = ~c; bus.div_factor = c_DIV_W'(div + 3);
      end
      prev = sclk;
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_byte"}, got, exp_byte);
    chk({tag, "_sce_low_len"}, cyc, exp_len);
    chk({tag, "_rises"}, rises, 8);
    chk({tag, "_avail_cnt"}, avails, 1);
    chk({tag, "_sclk_period"}, bad_period, 0);
    chk({tag, "_sclk_idle"}, sclk, 0);
    wait_idle();
    chk({tag, "_dc_hold"}, dc, exp_dc);
  endtask

  task automatic check_rst_pulse(input string tag);
    int n = 0, viol = 0;
    do begin
      @(negedge clock);
      n++;
      if (!rst && (bus.avail || !sce || sclk || !bus.busy)) viol++;
    end while (!rst && n < 100);
    bus.start = 1'b0;
    chk({tag, "_rst_len"}, n, c_RST_CYCLES);
    chk({tag, "_rst_phase_viol"}, viol, 0);
    chk({tag, "_idle_after_rst"}, bus.busy, 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h21, 1'b0, 2, 8'h21, 1'b0, 32};
    vecs[1] = '{8'hAA, 1'b1, 3, 8'hAA, 1'b1, 48};
    vecs[2] = '{8'hFF, 1'b0, 0, 8'hFF, 1'b0, 16};
    vecs[3] = '{8'h01, 1'b1, 1, 8'h01, 1'b1, 16};
    vecs[4] = '{8'h80, 1'b0, 4, 8'h80, 1'b0, 64};

    Reset = 1'b0;
    bus.data_in = 8'h5A; bus.command = 1'b1; bus.div_factor = 16'd2; bus.start = 1'b1;
    repeat (5) @(negedge clock);
    chk("reset_sclk", sclk, 0);
    chk("reset_sce", sce, 1);
    chk("reset_mosi", mosi, 0);
    chk("reset_dc", dc, 0);
    chk("reset_rst", rst, 0);
    chk("reset_busy", bus.busy, 1);
    chk("reset_avail", bus.avail, 0);

    // start held high through the LCD reset phase must be ignored
    Reset = 1'b1;
    check_rst_pulse("por");

    foreach (vecs[i])
      check_byte($sformatf("vec%0d", i), vecs[i].data, vecs[i].cmd, vecs[i].div,
                 vecs[i].exp_byte, vecs[i].exp_dc, vecs[i].exp_len);

    for (int i = 0; i < 12; i++) begin
      logic [7:0] d = 8'($urandom);
      logic c = 1'($urandom);
      int div = int'($urandom_range(0, 4));
      int eff = (div == 0) ? 1 : div;
      check_byte($sformatf("rnd%0d", i), d, c, div, d, c, 16 * eff);
    end

    // Two back-to-back bytes with start held high
    begin
      logic [15:0] stream = '0;
      logic prev = 1'b0;
      int t = 0, a1 = -1, a2 = -1, nav = 0, rises = 0, dc_bad = 0, sce_gap = 0;
      wait_idle();
      @(negedge clock);
      bus.data_in = 8'h90; bus.command = 1'b1; bus.div_factor = 16'd2; bus.start = 1'b1;
      while (t < 400) begin
        @(negedge clock);
        t++;
        if (bus.avail) begin
          nav++;
          if (nav == 1) begin a1 = t; bus.data_in = 8'h0C; end
          else begin a2 = t; bus.start = 1'b0; end
        end
        if (sclk && !prev) begin stream = {stream[14:0], mosi}; rises++; end
        prev = sclk;
        if (!sce && !dc) dc_bad++;
        if (nav == 1 && sce) sce_gap++;
        if (nav >= 2 && rises == 16 && sce) break;
      end
      chk("b2b_avail_cnt", nav, 2);
      chk("b2b_stream", stream, 16'h900C);
      chk("b2b_spacing", a2 - a1, c_BURST ? 32 : 35);
      chk("b2b_sce_high", sce_gap, c_BURST ? 0 : 3);
      chk("b2b_dc", dc_bad, 0);
    end

    // Reset asserted mid-byte after the third rising sclk edge
    begin
      logic prev = 1'b0;
      int t = 0, rises = 0, avails = 0;
      wait_idle();
      @(negedge clock);
      bus.data_in = 8'hC3; bus.command = 1'b1; bus.div_factor = 16'd3; bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      while (rises < 3 && t < 200) begin
        if (sclk && !prev) rises++;
        prev = sclk;
        if (rises < 3) begin @(negedge clock); t++; end
      end
      chk("mid_rises_reached", rises, 3);
      Reset = 1'b0;
      #1;
      chk("mid_sclk", sclk, 0);
      chk("mid_sce", sce, 1);
      chk("mid_mosi", mosi, 0);
      chk("mid_dc", dc, 0);
      chk("mid_rst", rst, 0);
      chk("mid_busy", bus.busy, 1);
      bus.start = 1'b1;
      repeat (3) begin
        @(negedge clock);
        if (bus.avail) avails++;
      end
      chk("mid_no_avail", avails, 0);
      Reset = 1'b1;
      check_rst_pulse("mid");
      check_byte("post_rst", 8'h3C, 1'b0, 2, 8'h3C, 1'b0, 32);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
